// File: rtl/axi_xbar_pkg.sv
// rtl/axi_xbar_pkg.sv - shared address map, width helper and slice entry type for the crossbar address path
package axi_xbar_pkg;

  function automatic int tgt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int XBAR_NUM_SLAVES = 6;
  localparam int XBAR_ADDR_W     = 32;
  localparam int XBAR_ID_W       = 4;
  localparam int XBAR_TGT_W      = tgt_w(XBAR_NUM_SLAVES);

  // Entry i sits at bits [i*ADDR_W +: ADDR_W]; the leftmost constant is slave 5.
  localparam logic [XBAR_NUM_SLAVES*XBAR_ADDR_W-1:0] XBAR_SLV_BASE = {
    32'h2000_0000, 32'h1001_0000, 32'h1000_0000,
    32'h0002_0000, 32'h0001_0000, 32'h0000_0000
  };
  localparam logic [XBAR_NUM_SLAVES*XBAR_ADDR_W-1:0] XBAR_SLV_LAST = {
    32'h207F_FFFF, 32'h1001_03FF, 32'h1000_03FF,
    32'h0002_FFFF, 32'h0001_FFFF, 32'h0000_3FFF
  };

  typedef struct packed {
    logic [XBAR_TGT_W-1:0]  target;
    logic [XBAR_ADDR_W-1:0] addr;
    logic [XBAR_ID_W-1:0]   id;
  } slice_t;

endpackage

// File: rtl/axi_addr_match.sv
// rtl/axi_addr_match.sv - combinational address-to-target decoder; no hit yields NUM_SLAVES
module axi_addr_match
  import axi_xbar_pkg::*;
#(
  parameter int NUM_SLAVES = XBAR_NUM_SLAVES,
  parameter int ADDR_W     = XBAR_ADDR_W,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = XBAR_SLV_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_LAST = XBAR_SLV_LAST,
  localparam int TGT_W = tgt_w(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [TGT_W-1:0]  target_o
);

  // Scan from the top so the lowest-index hit is the last one written.
  always_comb begin
    target_o = TGT_W'(NUM_SLAVES);
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr_i >= SLV_BASE[i*ADDR_W +: ADDR_W]) && (addr_i <= SLV_LAST[i*ADDR_W +: ADDR_W])) begin
        target_o = TGT_W'(i);
      end
    end
  end

endmodule

// File: rtl/axi_addr_router.sv
// rtl/axi_addr_router.sv - address-channel router: decode, one-entry output slice, in-order target lock
module axi_addr_router
  import axi_xbar_pkg::*;
#(
  parameter int NUM_SLAVES      = XBAR_NUM_SLAVES,
  parameter int ADDR_W          = XBAR_ADDR_W,
  parameter int ID_W            = XBAR_ID_W,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = XBAR_SLV_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_LAST = XBAR_SLV_LAST,
  localparam int TGT_W = tgt_w(NUM_SLAVES),
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  S_VALID,
  output logic                  S_READY,
  input  logic [ADDR_W-1:0]     S_ADDR,
  input  logic [ID_W-1:0]       S_ID,
  output logic [NUM_SLAVES-1:0] M_VALID,
  input  logic [NUM_SLAVES-1:0] M_READY,
  output logic [ADDR_W-1:0]     M_ADDR,
  output logic [ID_W-1:0]       M_ID,
  output logic                  DEC_ERR_VALID,
  input  logic                  DEC_ERR_READY,
  input  logic                  RESP_DONE,
  output logic [TGT_W-1:0]      TARGET,
  output logic [CNT_W-1:0]      OUTSTANDING
);

  logic [TGT_W-1:0] dec_tgt;
  slice_t           slice_q, slice_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff;
  logic             sel_ready, drain, resp, blocked, accept;

  axi_addr_match #(
    .NUM_SLAVES(NUM_SLAVES),
    .ADDR_W    (ADDR_W),
    .SLV_BASE  (SLV_BASE),
    .SLV_LAST  (SLV_LAST)
  ) u_match (
    .addr_i  (S_ADDR),
    .target_o(dec_tgt)
  );

  always_comb begin
    sel_ready = DEC_ERR_READY;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slice_q.target == TGT_W'(i)) sel_ready = M_READY[i];
    end
  end

  assign drain = valid_q && sel_ready;
  assign resp  = RESP_DONE && (cnt_q != '0);

  // Count as it stands once this cycle's response retires, so a full or
  // locked path can accept in the very cycle RESP_DONE frees it.
  assign cnt_eff = cnt_q - CNT_W'(resp);
  assign blocked = (cnt_eff == CNT_W'(MAX_OUTSTANDING)) ||
                   ((cnt_eff != '0) && (dec_tgt != slice_q.target));

  assign S_READY = (!valid_q || drain) && !blocked;
  assign accept  = S_VALID && S_READY;

  always_comb begin
    valid_d = valid_q;
    slice_d = slice_q;
    cnt_d   = cnt_eff;
    if (drain) valid_d = 1'b0;
    if (accept) begin
      valid_d        = 1'b1;
      slice_d.target = dec_tgt;
      slice_d.addr   = S_ADDR;
      slice_d.id     = S_ID;
      cnt_d          = cnt_eff + CNT_W'(1);
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      valid_q <= 1'b0;
      slice_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      slice_q <= slice_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    M_VALID = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      M_VALID[i] = valid_q && (slice_q.target == TGT_W'(i));
    end
  end

  assign DEC_ERR_VALID = valid_q && (slice_q.target == TGT_W'(NUM_SLAVES));
  assign M_ADDR        = slice_q.addr;
  assign M_ID          = slice_q.id;
  assign TARGET        = slice_q.target;
  assign OUTSTANDING   = cnt_q;

endmodule

// File: tb/tb_axi_addr_router.sv
// tb/tb_axi_addr_router.sv - scoreboard bench for axi_addr_router with directed corners and random traffic
module tb_axi_addr_router;

  localparam int NS   = 6;
  localparam int MAXO = 4;

  logic        ACLK, ARESET, S_VALID, S_READY;
  logic [31:0] S_ADDR, M_ADDR;
  logic [3:0]  S_ID, M_ID;
  logic [5:0]  M_VALID, M_READY;
  logic        DEC_ERR_VALID, DEC_ERR_READY, RESP_DONE;
  logic [2:0]  TARGET, OUTSTANDING;

  axi_addr_router #(.MAX_OUTSTANDING(MAXO)) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .S_VALID      (S_VALID),
    .S_READY      (S_READY),
    .S_ADDR       (S_ADDR),
    .S_ID         (S_ID),
    .M_VALID      (M_VALID),
    .M_READY      (M_READY),
    .M_ADDR       (M_ADDR),
    .M_ID         (M_ID),
    .DEC_ERR_VALID(DEC_ERR_VALID),
    .DEC_ERR_READY(DEC_ERR_READY),
    .RESP_DONE    (RESP_DONE),
    .TARGET       (TARGET),
    .OUTSTANDING  (OUTSTANDING)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    int          tgt;
    logic [31:0] addr;
    logic [3:0]  id;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   m_cnt = 0;
  int   m_tgt = 0;

  int unsigned base_a[NS] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000,
                              32'h1000_0000, 32'h1001_0000, 32'h2000_0000};
  int unsigned last_a[NS] = '{32'h0000_3FFF, 32'h0001_FFFF, 32'h0002_FFFF,
                              32'h1000_03FF, 32'h1001_03FF, 32'h207F_FFFF};

  logic [31:0] corner_a[6] = '{32'h0000_3FFF, 32'h0000_4000, 32'h0001_0000,
                               32'h1000_03FF, 32'h207F_FFFF, 32'h2080_0000};
  int          corner_t[6] = '{0, 6, 1, 3, 5, 6};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if (a >= base_a[i] && a <= last_a[i]) return i;
    end
    return NS;
  endfunction

  function automatic logic [31:0] rand_addr();
    int j = $urandom_range(0, NS - 1);
    case ($urandom_range(0, 4))
      0, 1:    return base_a[j] + ($urandom % (last_a[j] - base_a[j] + 1));
      2:       return last_a[j] + 1;
      3:       return $urandom;
      default: return (j == 0) ? last_a[j] : base_a[j] - 1;
    endcase
  endfunction

  task automatic nxt();
    @(posedge ACLK);
    #1;
  endtask

  // Monitor: scoreboard pop on output handshake, push on input accept.
  bit          hold = 0;
  logic [5:0]  p_mv;
  logic        p_de;
  logic [31:0] p_addr;
  logic [3:0]  p_id;

  always @(negedge ACLK) begin
    int   ot, t, eff;
    bit   rdy, resp;
    exp_t e;
    if (ARESET) begin
      exp_q.delete();
      m_cnt = 0;
      m_tgt = 0;
      hold  = 0;
    end else begin
      chk("onehot", ($countones({DEC_ERR_VALID, M_VALID}) <= 1), 1);
      chk("outstanding", OUTSTANDING, m_cnt);
      chk("target", TARGET, m_tgt);
      if (hold) begin
        chk("stable_mvalid", {p_de, p_mv}, {DEC_ERR_VALID, M_VALID});
        chk("stable_addr", M_ADDR, p_addr);
        chk("stable_id", M_ID, p_id);
      end
      hold = 0;
      if (DEC_ERR_VALID || (M_VALID != 0)) begin
        ot = NS;
        for (int i = NS - 1; i >= 0; i--) if (M_VALID[i]) ot = i;
        rdy = (ot == NS) ? DEC_ERR_READY : M_READY[ot];
        if (rdy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_target", ot, e.tgt);
            chk("out_addr", M_ADDR, e.addr);
            chk("out_id", M_ID, e.id);
          end
        end else begin
          hold   = 1;
          p_mv   = M_VALID;
          p_de   = DEC_ERR_VALID;
          p_addr = M_ADDR;
          p_id   = M_ID;
        end
      end
      chk("resp_underflow", (RESP_DONE && m_cnt == 0), 0);
      resp = RESP_DONE && (m_cnt > 0);
      eff  = m_cnt - (resp ? 1 : 0);
      if (S_VALID && S_READY) begin
        t = ref_decode(S_ADDR);
        chk("order_lock", (eff != 0 && t != m_tgt), 0);
        chk("limit", (eff >= MAXO), 0);
        exp_q.push_back('{tgt: t, addr: S_ADDR, id: S_ID});
        m_tgt = t;
        m_cnt = eff + 1;
      end else begin
        m_cnt = eff;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit acc;
    ARESET = 1; S_VALID = 0; S_ADDR = 0; S_ID = 0;
    M_READY = '1; DEC_ERR_READY = 1; RESP_DONE = 0;
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_mvalid", M_VALID, 0);
    chk("rst_dec_err", DEC_ERR_VALID, 0);
    chk("rst_addr", M_ADDR, 0);
    chk("rst_id", M_ID, 0);
    chk("rst_target", TARGET, 0);
    chk("rst_outstanding", OUTSTANDING, 0);
    ARESET = 0;
    @(negedge ACLK);
    chk("idle_s_ready", S_READY, 1);

    for (int k = 0; k < 6; k++) begin
      nxt(); S_VALID = 1; S_ADDR = corner_a[k]; S_ID = 4'(k); RESP_DONE = 0;
      @(negedge ACLK);
      chk("map_ready", S_READY, 1);
      nxt(); S_VALID = 0; RESP_DONE = 1;
      @(negedge ACLK);
      chk("map_target", TARGET, corner_t[k]);
      chk("map_dec_err", DEC_ERR_VALID, (corner_t[k] == 6));
      chk("map_mvalid", M_VALID, (corner_t[k] < 6) ? 6'(1 << corner_t[k]) : 6'h0);
    end
    nxt(); RESP_DONE = 0;

    for (int k = 0; k < 9; k++) begin
      nxt(); S_VALID = (k < 8); S_ADDR = 32'h0002_0010; S_ID = 4'(k); RESP_DONE = (k >= 1);
      @(negedge ACLK);
      if (k < 8) chk("stream_ready", S_READY, 1);
      if (k >= 1) begin
        chk("stream_mvalid", M_VALID, 6'b000100);
        chk("stream_id", M_ID, 4'(k - 1));
      end
      chk("stream_outstanding_le2", (OUTSTANDING <= 2), 1);
    end
    nxt(); S_VALID = 0; RESP_DONE = 0;

    nxt(); M_READY = 6'b111101; S_VALID = 1; S_ADDR = 32'h0001_0000; S_ID = 4'h5;
    @(negedge ACLK);
    chk("bp_accept", S_READY, 1);
    nxt(); S_ADDR = 32'h0001_0004; S_ID = 4'h6;
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      chk("bp_mvalid", M_VALID, 6'b000010);
      chk("bp_addr", M_ADDR, 32'h0001_0000);
      chk("bp_id", M_ID, 4'h5);
      chk("bp_s_ready", S_READY, 0);
      nxt();
    end
    M_READY = '1;
    @(negedge ACLK);
    chk("bp_drain_ready", S_READY, 1);
    nxt(); S_VALID = 0;
    @(negedge ACLK);
    chk("bp_second_addr", M_ADDR, 32'h0001_0004);
    chk("bp_second_id", M_ID, 4'h6);
    chk("bp_outstanding", OUTSTANDING, 2);
    nxt(); RESP_DONE = 1;
    nxt();
    nxt(); RESP_DONE = 0;

    nxt(); S_VALID = 1; S_ADDR = 32'h0000_0100; S_ID = 4'h1;
    @(negedge ACLK);
    chk("lock_acc1", S_READY, 1);
    nxt(); S_ADDR = 32'h0000_0200; S_ID = 4'h2;
    @(negedge ACLK);
    chk("lock_acc2", S_READY, 1);
    nxt(); S_ADDR = 32'h1001_0000; S_ID = 4'h3;
    @(negedge ACLK);
    chk("lock_stall0", S_READY, 0);
    chk("lock_target0", TARGET, 0);
    nxt(); RESP_DONE = 1;
    @(negedge ACLK);
    chk("lock_stall1", S_READY, 0);
    nxt(); RESP_DONE = 0;
    @(negedge ACLK);
    chk("lock_stall2", S_READY, 0);
    nxt(); RESP_DONE = 1;
    @(negedge ACLK);
    chk("lock_accept_on_resp", S_READY, 1);
    nxt(); S_VALID = 0; RESP_DONE = 0;
    @(negedge ACLK);
    chk("lock_target4", TARGET, 4);
    chk("lock_outstanding", OUTSTANDING, 1);
    chk("lock_mvalid", M_VALID, 6'b010000);
    nxt(); RESP_DONE = 1;
    nxt(); RESP_DONE = 0;

    for (int k = 0; k < 6; k++) begin
      nxt(); S_VALID = 1; RESP_DONE = (k == 5);
      if (k <= 4) begin
        S_ADDR = 32'h2000_0000 + 32'(k * 16);
        S_ID   = 4'(k);
      end
      @(negedge ACLK);
      if (k < 4) begin
        chk("limit_accept", S_READY, 1);
      end else if (k == 4) begin
        chk("limit_stall", S_READY, 0);
        chk("limit_full", OUTSTANDING, 4);
      end else begin
        chk("limit_accept_on_resp", S_READY, 1);
      end
    end
    nxt(); S_VALID = 0; RESP_DONE = 0;
    @(negedge ACLK);
    chk("limit_held_at_max", OUTSTANDING, 4);
    nxt(); RESP_DONE = 1;
    repeat (3) nxt();
    nxt(); RESP_DONE = 0;

    nxt(); M_READY = 6'b111101; S_VALID = 1; S_ADDR = 32'h0001_0040; S_ID = 4'h9;
    nxt(); S_VALID = 0;
    #2;
    chk("pre_rst_valid", M_VALID, 6'b000010);
    ARESET = 1;
    #1;
    chk("mid_rst_mvalid", M_VALID, 0);
    chk("mid_rst_dec_err", DEC_ERR_VALID, 0);
    chk("mid_rst_addr", M_ADDR, 0);
    chk("mid_rst_id", M_ID, 0);
    chk("mid_rst_target", TARGET, 0);
    chk("mid_rst_outstanding", OUTSTANDING, 0);
    nxt(); ARESET = 0; M_READY = '1;
    @(negedge ACLK);
    chk("post_rst_s_ready", S_READY, 1);
    chk("post_rst_mvalid", M_VALID, 0);

    acc = 1;
    for (int c = 0; c < 800; c++) begin
      nxt();
      if (acc || !S_VALID) begin
        S_VALID = ($urandom_range(0, 3) != 0);
        S_ADDR  = rand_addr();
        S_ID    = 4'($urandom);
      end
      M_READY       = 6'($urandom);
      DEC_ERR_READY = 1'($urandom);
      RESP_DONE     = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
      @(negedge ACLK);
      acc = S_VALID && S_READY;
    end

    nxt(); S_VALID = 0; M_READY = '1; DEC_ERR_READY = 1; RESP_DONE = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge ACLK);
      #1;
      if (m_cnt == 0 && exp_q.size() == 0) break;
      nxt();
      RESP_DONE = (m_cnt > 0);
    end
    chk("drain_count", m_cnt, 0);
    chk("drain_queue", exp_q.size(), 0);
    nxt(); RESP_DONE = 0;
    @(negedge ACLK);
    chk("final_outstanding", OUTSTANDING, 0);
    chk("final_mvalid", {DEC_ERR_VALID, M_VALID}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
